gate_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises a 3-input combinational gate (XNOR by default) in hardware. On `start`, it drives the gate's `a`, `b`, `c` inputs through all 8 combinations in ascending order. Each vector is held for a programmable number of cycles, and the gate output is checked against a parameterised truth table. It sits between a top-level control or status interface and the gate under test, replacing the timed-stimulus sweep with a clocked, self-checking controller.

---
 rtl/gate_sweep_ctrl.sv | 112 +++++++++++
 tb/tb_gate_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Clocked sweep controller for a 3-input combinational gate: steps {a,b,c}
// through 000..111, holds each vector HOLD cycles and checks F against TRUTH.
module gate_sweep_ctrl #(
    parameter int unsigned HOLD  = 4,
    parameter logic [7:0]  TRUTH = 8'h69
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_mask,
    output logic [3:0] err_cnt,
    output logic [2:0] vec_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] vec_q, vec_d;
    logic [7:0] mask_q, mask_d;
    logic [3:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       done_q, done_d;
    logic       mismatch;

    // NOTE: every signal gets its default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        vec_d    = vec_q;
        mask_d   = mask_q;
        err_d    = err_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        mismatch = (f_in != TRUTH[vec_q]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    hold_d  = 8'd0;
                    vec_d   = 3'd0;
                    mask_d  = 8'd0;
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    hold_d = 8'd0;
                    if (mismatch) begin
                        mask_d[vec_q] = 1'b1;
                        err_d         = err_q + 4'd1;
                    end
                    if (vec_q != 3'd7) begin
                        vec_d = vec_q + 3'd1;
                    end else begin
                        // Final vector: err_d already includes its verdict.
                        state_d = IDLE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 4'd0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            vec_q   <= 3'd0;
            mask_q  <= 8'd0;
            err_q   <= 4'd0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign {a, b, c} = vec_q;
    assign vec_idx   = vec_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = mask_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: HOLD=4 and HOLD=1 instances,
// per-sweep expected results queued at start and compared at done.
module tb_gate_sweep_ctrl;

    typedef struct {
        logic [7:0] mask;
        logic [3:0] err;
        logic       pass;
    } exp_t;

    localparam int MODE_XNOR = 0;
    localparam int MODE_ZERO = 1;
    localparam int MODE_XOR  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    exp_t sb[$];

    // HOLD=4 instance
    logic       rst4, start4, f4;
    logic       a4, b4, c4, busy4, done4, pass4;
    logic [7:0] mask4;
    logic [3:0] err4;
    logic [2:0] vec4;
    int         mode4 = MODE_XNOR;

    // HOLD=1 instance
    logic       rst1, start1, f1;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [7:0] mask1;
    logic [3:0] err1;
    logic [2:0] vec1;

    gate_sweep_ctrl #(.HOLD(4), .TRUTH(8'h69)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .f_in(f4),
        .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
        .fail_mask(mask4), .err_cnt(err4), .vec_idx(vec4)
    );

    gate_sweep_ctrl #(.HOLD(1), .TRUTH(8'h69)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .f_in(f1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(mask1), .err_cnt(err1), .vec_idx(vec1)
    );

    function automatic logic gate_model(input int mode, input logic x, input logic y, input logic z);
        case (mode)
            MODE_ZERO: return 1'b0;
            MODE_XOR:  return x ^ y ^ z;
            default:   return ~(x ^ y ^ z);
        endcase
    endfunction

    always_comb f4 = gate_model(mode4, a4, b4, c4);
    always_comb f1 = gate_model(MODE_XNOR, a1, b1, c1);

    function automatic exp_t expect_for(input int mode);
        exp_t e;
        logic [2:0] k;
        logic truth, f;
        e.mask = 8'h00;
        e.err  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            k     = 3'(i);
            truth = ~(k[2] ^ k[1] ^ k[0]);
            f     = gate_model(mode, k[2], k[1], k[0]);
            if (f != truth) begin
                e.mask[i] = 1'b1;
                e.err     = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    task automatic test_reset();
        rst4 = 1'b1; rst1 = 1'b1; start4 = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy4, done4, pass4, mask4, err4, vec4, a4, b4, c4} !== 21'd0) begin
            n_mis++;
            $display("FAIL reset4: got busy=%b done=%b pass=%b mask=%h err=%0d vec=%0d, want all 0",
                     busy4, done4, pass4, mask4, err4, vec4);
        end
        n_vec++;
        if ({busy1, done1, pass1, mask1, err1, vec1, a1, b1, c1} !== 21'd0) begin
            n_mis++;
            $display("FAIL reset1: got busy=%b done=%b pass=%b mask=%h err=%0d vec=%0d, want all 0",
                     busy1, done1, pass1, mask1, err1, vec1);
        end
        rst4 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
    endtask

    // One HOLD=4 sweep. restart: pulse start at E0+10. abort: rst at E0+13.
    task automatic sweep4(input string name, input int mode, input bit restart, input bit abort);
        exp_t e;
        @(negedge clk);
        mode4  = mode;
        start4 = 1'b1;
        if (!abort) sb.push_back(expect_for(mode));
        for (int n = 0; n <= 35; n++) begin
            @(negedge clk);   // n cycles after edge E0
            start4 = (restart && n == 9);
            if (abort && n == 12) rst4 = 1'b1;
            if (abort && n == 13) begin
                rst4 = 1'b0;
                n_vec++;
                if ({busy4, done4, pass4, mask4, err4, vec4, a4, b4, c4} !== 21'd0) begin
                    n_mis++;
                    $display("FAIL %s mid-reset: got busy=%b done=%b mask=%h err=%0d vec=%0d, want all 0",
                             name, busy4, done4, mask4, err4, vec4);
                end
            end else if (abort && n > 13) begin
                n_vec++;
                if (busy4 !== 1'b0 || done4 !== 1'b0 || vec4 !== 3'd0) begin
                    n_mis++;
                    $display("FAIL %s post-reset n=%0d: got busy=%b done=%b vec=%0d, want 0/0/0",
                             name, n, busy4, done4, vec4);
                end
                if (n == 16) break;
            end else if (n < 32) begin
                n_vec++;
                if (busy4 !== 1'b1 || done4 !== 1'b0 || vec4 !== 3'(n / 4) || {a4, b4, c4} !== 3'(n / 4)) begin
                    n_mis++;
                    $display("FAIL %s step n=%0d: got busy=%b done=%b vec=%0d abc=%b%b%b, want 1/0/%0d",
                             name, n, busy4, done4, vec4, a4, b4, c4, n / 4);
                end
            end else if (n == 32) begin
                n_vec++;
                if (done4 !== 1'b1 || busy4 !== 1'b0 || vec4 !== 3'd7) begin
                    n_mis++;
                    $display("FAIL %s done: got done=%b busy=%b vec=%0d, want 1/0/7", name, done4, busy4, vec4);
                end
                n_vec++;
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL %s scoreboard: got done with empty queue, want a queued sweep", name);
                end else begin
                    e = sb.pop_front();
                    if (mask4 !== e.mask || err4 !== e.err || pass4 !== e.pass) begin
                        n_mis++;
                        $display("FAIL %s results: got mask=%h err=%0d pass=%b, want mask=%h err=%0d pass=%b",
                                 name, mask4, err4, pass4, e.mask, e.err, e.pass);
                    end
                end
            end else if (n == 35) begin
                n_vec++;
                if (done4 !== 1'b0 || busy4 !== 1'b0 || mask4 !== e.mask || err4 !== e.err || pass4 !== e.pass) begin
                    n_mis++;
                    $display("FAIL %s idle hold: got done=%b busy=%b mask=%h err=%0d pass=%b, want 0/0/%h/%0d/%b",
                             name, done4, busy4, mask4, err4, pass4, e.mask, e.err, e.pass);
                end
            end else begin
                n_vec++;
                if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                    n_mis++;
                    $display("FAIL %s after done n=%0d: got done=%b busy=%b, want 0/0", name, n, done4, busy4);
                end
            end
        end
        start4 = 1'b0;
    endtask

    // HOLD=1 with start held high: done at E0+8, E0+17, E0+26.
    task automatic test_back_to_back();
        exp_t e;
        int   m;
        @(negedge clk);
        start1 = 1'b1;
        for (int s = 0; s < 3; s++) sb.push_back(expect_for(MODE_XNOR));
        for (int n = 0; n < 27; n++) begin
            @(negedge clk);
            m = n % 9;
            if (m < 8) begin
                n_vec++;
                if (busy1 !== 1'b1 || done1 !== 1'b0 || vec1 !== 3'(m) || {a1, b1, c1} !== 3'(m)) begin
                    n_mis++;
                    $display("FAIL b2b step n=%0d: got busy=%b done=%b vec=%0d, want 1/0/%0d",
                             n, busy1, done1, vec1, m);
                end
            end else begin
                n_vec++;
                if (done1 !== 1'b1 || busy1 !== 1'b0 || vec1 !== 3'd7 || sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL b2b done n=%0d: got done=%b busy=%b vec=%0d queued=%0d, want 1/0/7/>0",
                             n, done1, busy1, vec1, sb.size());
                end else begin
                    e = sb.pop_front();
                    n_vec++;
                    if (mask1 !== e.mask || err1 !== e.err || pass1 !== e.pass) begin
                        n_mis++;
                        $display("FAIL b2b results n=%0d: got mask=%h err=%0d pass=%b, want %h/%0d/%b",
                                 n, mask1, err1, pass1, e.mask, e.err, e.pass);
                    end
                end
            end
        end
        start1 = 1'b0;
        while (sb.size() > 0) void'(sb.pop_front());
    endtask

    initial begin
        test_reset();
        sweep4("xnor", MODE_XNOR, 1'b0, 1'b0);
        sweep4("zero", MODE_ZERO, 1'b0, 1'b0);
        sweep4("clear", MODE_XNOR, 1'b0, 1'b0);
        sweep4("xor", MODE_XOR, 1'b0, 1'b0);
        sweep4("restart", MODE_XNOR, 1'b1, 1'b0);
        sweep4("abort", MODE_XNOR, 1'b0, 1'b1);
        sweep4("after_abort", MODE_ZERO, 1'b0, 1'b0);
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, want finish within 200000 time units");
        $fatal(1);
    end

endmodule
